// File: rtl/regfile_pkg.sv
// Shared types and sizing helpers for the
// multi-port register file with scoreboard.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef logic [XLEN_DEF-1:0] word_t;

  function automatic int addr_w(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

endpackage

// File: rtl/regfile_sb_rdport.sv
// One read port: bypass priority mux, zero-reg
// masking and busy lookup with writeback clear.
module regfile_sb_rdport
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  parameter int AW       = addr_w(NREGS_DEF)
) (
  input  logic [AW-1:0]                rs_addr,
  input  logic [NREGS-1:0][XLEN-1:0]   regs,
  input  logic [NREGS-1:0]             busy,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]    wr_addr,
  input  logic [NUM_WR-1:0][XLEN-1:0]  wr_data,
  output logic [XLEN-1:0]              rs_data,
  output logic                         rs_busy
);

  localparam logic [AW:0] NR = (AW+1)'(NREGS);

  logic            in_rng;
  logic            is_zero;
  logic            hit;
  logic [XLEN-1:0] byp;

  assign in_rng  = {1'b0, rs_addr} < NR;
  assign is_zero = (ZERO_REG != 0) && (rs_addr == '0);

  // later ports overwrite earlier matches: highest index wins
  always_comb begin
    hit = 1'b0;
    byp = '0;
    for (int p = 0; p < NUM_WR; p++) begin
      if (wr_en[p] && wr_addr[p] == rs_addr) begin
        hit = 1'b1;
        byp = wr_data[p];
      end
    end
  end

  always_comb begin
    rs_data = '0;
    rs_busy = 1'b0;
    if (in_rng && !is_zero) begin
      if (BYPASS != 0 && hit) begin
        rs_data = byp;
        rs_busy = 1'b0;
      end else begin
        rs_data = regs[rs_addr];
        rs_busy = busy[rs_addr];
      end
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write bypass
// and per-register busy scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = addr_w(NREGS)
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_flush,
  input  logic [NUM_RD-1:0][AW-1:0]    i_rs_addr,
  output logic [NUM_RD-1:0][XLEN-1:0]  o_rs_data,
  output logic [NUM_RD-1:0]            o_rs_busy,
  input  logic [NUM_WR-1:0]            i_wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]    i_wr_addr,
  input  logic [NUM_WR-1:0][XLEN-1:0]  i_wr_data,
  input  logic                         i_iss_en,
  input  logic [AW-1:0]                i_iss_addr,
  output logic [NREGS-1:0]             o_busy_vec,
  output logic                         o_wr_conflict
);

  localparam logic [AW:0] NR = (AW+1)'(NREGS);

  logic [NREGS-1:0][XLEN-1:0] mem;
  logic [NREGS-1:0]           busy_q;
  logic [NREGS-1:0]           busy_d;
  logic [NREGS-1:0]           wb_hit;
  logic [NREGS-1:0]           iss_hit;
  logic [NUM_WR-1:0]          wr_ok;
  logic                       conf_d;
  logic                       conf_q;

  always_comb begin
    for (int p = 0; p < NUM_WR; p++) begin
      wr_ok[p] = i_wr_en[p] && ({1'b0, i_wr_addr[p]} < NR) &&
                 !((ZERO_REG != 0) && i_wr_addr[p] == '0);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      mem <= '0;
    end else begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_ok[p]) mem[i_wr_addr[p]] <= i_wr_data[p];
      end
    end
  end

  // flush beats issue, issue beats writeback clear
  always_comb begin
    wb_hit  = '0;
    iss_hit = '0;
    busy_d  = busy_q;
    for (int r = 0; r < NREGS; r++) begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (i_wr_en[p] && i_wr_addr[p] == AW'(r)) wb_hit[r] = 1'b1;
      end
      iss_hit[r] = i_iss_en && i_iss_addr == AW'(r);
      if ((ZERO_REG != 0) && r == 0) busy_d[r] = 1'b0;
      else if (i_flush)              busy_d[r] = 1'b0;
      else if (iss_hit[r])           busy_d[r] = 1'b1;
      else if (wb_hit[r])            busy_d[r] = 1'b0;
    end
  end

  always_comb begin
    conf_d = 1'b0;
    for (int p = 0; p < NUM_WR; p++) begin
      for (int q = p + 1; q < NUM_WR; q++) begin
        if (i_wr_en[p] && i_wr_en[q] &&
            i_wr_addr[p] == i_wr_addr[q] && i_wr_addr[p] != '0)
          conf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      busy_q <= '0;
      conf_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      conf_q <= conf_d;
    end
  end

  assign o_busy_vec    = busy_q;
  assign o_wr_conflict = conf_q;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [XLEN-1:0] d;
    regfile_sb_rdport #(
      .XLEN     (XLEN),
      .NREGS    (NREGS),
      .NUM_WR   (NUM_WR),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG),
      .AW       (AW)
    ) u_rd (
      .rs_addr  (i_rs_addr[i]),
      .regs     (mem),
      .busy     (busy_q),
      .wr_en    (i_wr_en),
      .wr_addr  (i_wr_addr),
      .wr_data  (i_wr_data),
      .rs_data  (d),
      .rs_busy  (o_rs_busy[i])
    );
    // bypass must not leak write data while reset is held
    assign o_rs_data[i] = i_reset ? '0 : d;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a bypassing and
// a non-bypassing instance share one stimulus.
module tb_regfile_sb;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [1:0][4:0]  rs_addr;
  logic [1:0][31:0] rd1, rd0;
  logic [1:0]       rb1, rb0;
  logic [1:0]       wr_en;
  logic [1:0][4:0]  wr_addr;
  logic [1:0][31:0] wr_data;
  logic             iss_en;
  logic [4:0]       iss_addr;
  logic [31:0]      bv1, bv0;
  logic             cf1, cf0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  regfile_sb #(.BYPASS(1)) u_dut (
    .i_clk(clk), .i_reset(rst), .i_flush(flush),
    .i_rs_addr(rs_addr), .o_rs_data(rd1), .o_rs_busy(rb1),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_iss_en(iss_en), .i_iss_addr(iss_addr),
    .o_busy_vec(bv1), .o_wr_conflict(cf1)
  );

  regfile_sb #(.BYPASS(0)) u_dut_nb (
    .i_clk(clk), .i_reset(rst), .i_flush(flush),
    .i_rs_addr(rs_addr), .o_rs_data(rd0), .o_rs_busy(rb0),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_iss_en(iss_en), .i_iss_addr(iss_addr),
    .o_busy_vec(bv0), .o_wr_conflict(cf0)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; wr_en = '0; iss_en = 0;
  endtask

  initial begin
    rst = 1; rs_addr = '0; wr_addr = '0; wr_data = '0; iss_addr = '0;
    idle();
    #1;
    check("rst_busy", bv1, 32'h0);
    check("rst_conf", {31'b0, cf1}, 32'h0);
    check("rst_rd", rd1[0], 32'h0);
    #11 rst = 0;
    tick();

    // x5 written and issued, then reset mid-cycle
    wr_en[0] = 1; wr_addr[0] = 5; wr_data[0] = 32'hDEADBEEF;
    iss_en = 1; iss_addr = 5;
    tick();
    idle(); rs_addr[0] = 5;
    #1;
    check("x5_val", rd1[0], 32'hDEADBEEF);
    check("x5_busy", bv1, 32'h0000_0020);
    #2 rst = 1;
    #1;
    check("amid_rd", rd1[0], 32'h0);
    check("amid_busy", bv1, 32'h0);
    #2 rst = 0;
    tick();
    check("post_rst_rd", rd1[0], 32'h0);

    // issue x7, then writeback with same-cycle read
    iss_en = 1; iss_addr = 7;
    tick();
    idle();
    wr_en[0] = 1; wr_addr[0] = 7; wr_data[0] = 32'h1234;
    rs_addr[0] = 7;
    #1;
    check("byp_data", rd1[0], 32'h1234);
    check("nobyp_data", rd0[0], 32'h0);
    check("byp_rsbusy", {31'b0, rb1[0]}, 32'h0);
    check("nobyp_rsbusy", {31'b0, rb0[0]}, 32'h1);
    tick();
    idle();
    #1;
    check("nobyp_next", rd0[0], 32'h1234);
    check("x7_clr", bv1, 32'h0);

    // same-address collision: higher port wins
    wr_en = 2'b11; wr_addr[0] = 3; wr_addr[1] = 3;
    wr_data[0] = 32'hAAAA; wr_data[1] = 32'h5555;
    rs_addr[1] = 3;
    #1;
    check("coll_byp", rd1[1], 32'h5555);
    tick();
    idle();
    #1;
    check("coll_val", rd1[1], 32'h5555);
    check("coll_val_nb", rd0[1], 32'h5555);
    check("coll_conf", {31'b0, cf1}, 32'h1);
    tick();
    check("conf_pulse", {31'b0, cf1}, 32'h0);

    // scoreboard on x9
    iss_en = 1; iss_addr = 9; rs_addr[0] = 9;
    tick();
    check("x9_set", bv1, 32'h0000_0200);
    check("x9_rsbusy", {31'b0, rb1[0]}, 32'h1);
    wr_en[1] = 1; wr_addr[1] = 9; wr_data[1] = 32'h99;
    tick();
    check("x9_iss_wb", bv1, 32'h0000_0200);
    idle();
    wr_en[0] = 1; wr_addr[0] = 9; wr_data[0] = 32'h77;
    tick();
    idle();
    #1;
    check("x9_clr", bv1, 32'h0);
    check("x9_val", rd1[0], 32'h77);

    // register zero: issue and double write ignored
    iss_en = 1; iss_addr = 0;
    wr_en = 2'b11; wr_addr[0] = 0; wr_addr[1] = 0;
    wr_data[0] = 32'hFFFF_FFFF; wr_data[1] = 32'hFFFF_FFFF;
    rs_addr[0] = 0; rs_addr[1] = 0;
    #1;
    check("x0_byp", rd1[0], 32'h0);
    check("x0_rsbusy", {31'b0, rb1[1]}, 32'h0);
    tick();
    idle();
    #1;
    check("x0_val", rd1[1], 32'h0);
    check("x0_busy", bv1, 32'h0);
    check("x0_noconf", {31'b0, cf1}, 32'h0);

    // flush wins over issue; concurrent write commits
    iss_en = 1; iss_addr = 1;
    tick();
    iss_addr = 2;
    tick();
    iss_addr = 4;
    tick();
    check("pre_flush", bv1, 32'h0000_0016);
    flush = 1; iss_addr = 6;
    wr_en[1] = 1; wr_addr[1] = 10; wr_data[1] = 32'hCAFE;
    tick();
    idle();
    rs_addr[0] = 10;
    #1;
    check("flush_busy", bv1, 32'h0);
    check("flush_wr", rd1[0], 32'hCAFE);
    check("flush_wr_nb", rd0[0], 32'hCAFE);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
